// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial 16-bit ALU: widths, opcodes, FSM states.
package alu_pkg;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned IDX_W = 4;

   // Opcode encodings; 3'b101..3'b111 are reserved and produce a zero result.
   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage : alu_pkg

// File: rtl/serial_bit_unit.sv
// One-bit ALU slice with its carry flop.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   abit,bbit : operand bits for the current lane
//   op        : operation (reserved encodings yield 0)
//   init      : preload carry (1 for SUB, else 0) at operation start
//   en        : advance carry to the carry-out of the current bit
//   rbit      : result bit for the current lane (combinational)
//   carry     : carry-out of the current bit (combinational, 0 for non-arith)
module serial_bit_unit
   import alu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic abit,
   input  logic bbit,
   input  op_t  op,
   input  logic init,
   input  logic en,
   output logic rbit,
   output logic carry
);

   logic carry_q;
   logic bx;

   // SUB adds the inverted B operand with a carry-in of 1.
   assign bx = (op == OP_SUB) ? ~bbit : bbit;

   // Per-bit function and carry-out.
   always_comb begin
      rbit  = 1'b0;
      carry = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            rbit  = abit ^ bx ^ carry_q;
            carry = (abit & bx) | (abit & carry_q) | (bx & carry_q);
         end
         OP_AND:  rbit = abit & bbit;
         OP_OR:   rbit = abit | bbit;
         OP_XOR:  rbit = abit ^ bbit;
         default: rbit = 1'b0;
      endcase
   end

   // Carry flop: preload at start, then follow the ripple one bit per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_q <= 1'b0;
      end else if (init) begin
         carry_q <= (op == OP_SUB);
      end else if (en) begin
         carry_q <= carry;
      end
   end

endmodule : serial_bit_unit

// File: rtl/serial_alu16.sv
// Bit-serial 16-bit ALU controller: latches operands/opcode on start, then
// computes one result bit per clock from LSB to MSB and reports flags.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : operation request, sampled only in IDLE
//   op, a, b : opcode and operands, sampled with start
//   sl       : current bit index (mux16/demux16 lane select), 0 outside RUN
//   busy     : high during the 16 RUN cycles
//   done     : one-cycle pulse when result/cout/zero are final
//   result   : result register, holds until the next accepted start
//   cout     : final carry for ADD/SUB (1 = no borrow on SUB), else 0
//   zero     : result == 0, updated together with done
module serial_alu16
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [IDX_W-1:0] sl,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero
);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   op_t              op_q;

   logic accept;
   logic run_en;
   op_t  unit_op;
   logic rbit;
   logic carry;

   assign accept = (state == IDLE) && start;
   assign run_en = (state == RUN);

   // The carry preload happens before op_q is loaded, so use the incoming opcode then.
   assign unit_op = accept ? op_t'(op) : op_q;

   // The index register is the lane select; it is 0 outside RUN.
   assign sl = idx;

   serial_bit_unit u_bit (
      .clk   (clk),
      .rst   (rst),
      .abit  (a_q[idx]),
      .bbit  (b_q[idx]),
      .op    (unit_op),
      .init  (accept),
      .en    (run_en),
      .rbit  (rbit),
      .carry (carry)
   );

   // Control FSM, index counter, operand and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_ADD;
         result <= '0;
         cout   <= 1'b0;
         zero   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  op_q   <= op_t'(op);
                  result <= '0;
                  idx    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               result[idx] <= rbit;
               if (idx == IDX_W'(WIDTH - 1)) begin
                  idx   <= '0;
                  cout  <= carry;
                  zero  <= ({rbit, result[WIDTH-2:0]} == '0);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule : serial_alu16

// File: tb/tb_serial_alu16.sv
// Directed self-checking bench for serial_alu16.
module tb_serial_alu16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  sl;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        cout;
   logic        zero;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t1;
   int t2;

   serial_alu16 dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .sl     (sl),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .zero   (zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op from IDLE and check the full 16-cycle schedule and results.
   task automatic do_op(input string tag, input logic [2:0] o, input logic [15:0] av,
                        input logic [15:0] bv, input logic [15:0] er, input logic ec,
                        input logic ez);
      start = 1'b1; op = o; a = av; b = bv;
      tick();
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check({tag, " sl"}, 32'(sl), 32'(k));
         check({tag, " busy"}, 32'(busy), 32'd1);
         check({tag, " done early"}, 32'(done), 32'd0);
         tick();
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " busy end"}, 32'(busy), 32'd0);
      check({tag, " sl done"}, 32'(sl), 32'd0);
      check({tag, " result"}, 32'(result), 32'(er));
      check({tag, " cout"}, 32'(cout), 32'(ec));
      check({tag, " zero"}, 32'(zero), 32'(ez));
      tick();
      check({tag, " done pulse"}, 32'(done), 32'd0);
      check({tag, " result hold"}, 32'(result), 32'(er));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst sl", 32'(sl), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst result", 32'(result), 32'd0);
      check("rst cout", 32'(cout), 32'd0);
      check("rst zero", 32'(zero), 32'd0);
      tick();

      do_op("add1", 3'b000, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);
      do_op("add2", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
      do_op("sub1", 3'b001, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);
      do_op("sub2", 3'b001, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
      do_op("and",  3'b010, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0);
      do_op("or",   3'b011, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0);
      do_op("xor",  3'b100, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0);

      // Mid-run start pulse is ignored; reset mid-run discards the op.
      start = 1'b1; op = 3'b000; a = 16'h00FF; b = 16'h0001;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (k == 5) begin
            start = 1'b1; op = 3'b100; a = 16'hAAAA; b = 16'h5555;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      check("ignore sl", 32'(sl), 32'd9);
      check("ignore busy", 32'(busy), 32'd1);
      check("ignore partial", 32'(result), 32'h0100 & 32'h01FF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst result", 32'(result), 32'd0);
      check("midrst sl", 32'(sl), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      do_op("post rst", 3'b000, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

      do_op("reserved", 3'b111, 16'hFFFF, 16'h1234, 16'h0000, 1'b0, 1'b1);

      // Start held high: back-to-back ops through DONE and one IDLE cycle.
      start = 1'b1; op = 3'b000; a = 16'h0003; b = 16'h0004;
      for (int i = 0; i < 40 && done !== 1'b1; i++) tick();
      check("b2b done1", 32'(done), 32'd1);
      check("b2b result1", 32'(result), 32'h0007);
      t1 = cyc;
      tick();
      for (int i = 0; i < 40 && done !== 1'b1; i++) tick();
      check("b2b done2", 32'(done), 32'd1);
      check("b2b result2", 32'(result), 32'h0007);
      t2 = cyc;
      check("b2b period", 32'(t2 - t1), 32'd18);
      start = 1'b0;
      tick();
      tick();
      tick();
      check("b2b idle busy", 32'(busy), 32'd0);
      check("b2b idle done", 32'(done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_serial_alu16
